// File: rtl/warp_pkg.sv
// Shared constants, FSM state encoding and FIFO payload type for the warp issue unit.
package warp_pkg;

  localparam int unsigned NUM_LANES          = 8;
  localparam int unsigned INST_W             = 32;
  localparam int unsigned FIFO_DEPTH_DEF     = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT
  } issue_state_e;

  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [NUM_LANES-1:0] mask;
  } issue_entry_t;

  // Masked-off lanes count as ready so they never hold up issue or retire.
  function automatic logic lanes_idle(input logic [NUM_LANES-1:0] ready,
                                      input logic [NUM_LANES-1:0] mask);
    return &(ready | ~mask);
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous FIFO without fall-through; head entry is readable while non-empty.
module issue_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/warp_issue_unit.sv
// Warp issue unit: queues decoded instructions and broadcasts each to its masked lanes in lockstep.
// Optional watchdog enabled by defining WARP_ISSUE_TIMEOUT_EN.
module warp_issue_unit
  import warp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
`ifdef WARP_ISSUE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inst_valid,
  input  logic [INST_W-1:0]                 inst_data,
  input  logic [NUM_LANES-1:0]              inst_mask,
  output logic                              inst_ready,
  output logic                              lane_execute,
  output logic [INST_W-1:0]                 lane_instruction,
  output logic [NUM_LANES-1:0]              lane_enable,
  input  logic [NUM_LANES-1:0]              lane_ready,
  output logic                              busy,
  output logic                              retire_valid,
  output logic [15:0]                       retire_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              timeout_err
);

  localparam int unsigned ENTRY_W = $bits(issue_entry_t);

  issue_state_e         state;
  issue_state_e         state_n;
  issue_entry_t         wentry;
  issue_entry_t         head;
  logic [ENTRY_W-1:0]   head_bits;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 timer_hit;
  logic [INST_W-1:0]    inst_r;
  logic [NUM_LANES-1:0] mask_r;
  logic [15:0]          retire_cnt_r;

  assign wentry = '{inst: inst_data, mask: inst_mask};
  assign head   = issue_entry_t'(head_bits);
  assign push   = inst_valid && !fifo_full;

  issue_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef WARP_ISSUE_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES+1);

  logic [TMR_W-1:0] timer_r;
  logic             timeout_r;

  // Per-instruction watchdog: restarted by every pop, runs while an instruction is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (pop)                   timer_r <= '0;
      else if (state != ST_IDLE) timer_r <= timer_r + TMR_W'(1);
      if (timer_hit && !retire_valid) timeout_r <= 1'b1;
    end
  end

  assign timer_hit   = (state != ST_IDLE) && (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_r;
`else
  assign timer_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state, FIFO pop, issue pulse and retire pulse.
  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    lane_execute = 1'b0;
    retire_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mask_r == '0) begin
          retire_valid = 1'b1;
        end else if (lanes_idle(lane_ready, mask_r)) begin
          lane_execute = 1'b1;
          state_n      = ST_SETTLE;
        end
      end
      ST_SETTLE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (lanes_idle(lane_ready, mask_r)) retire_valid = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (retire_valid) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        state_n = ST_ISSUE;
      end else begin
        state_n = ST_IDLE;
      end
    end
`ifdef WARP_ISSUE_TIMEOUT_EN
    // Abandon a hung instruction; a retire in the same cycle wins.
    if (timer_hit && !retire_valid) begin
      lane_execute = 1'b0;
      pop          = 1'b0;
      state_n      = ST_IDLE;
    end
`endif
  end

  // In-flight instruction registers and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_r       <= '0;
      mask_r       <= '0;
      retire_cnt_r <= '0;
    end else begin
      if (pop) begin
        inst_r <= head.inst;
        mask_r <= head.mask;
      end else if (state_n == ST_IDLE) begin
        inst_r <= '0;
        mask_r <= '0;
      end
      if (retire_valid) retire_cnt_r <= retire_cnt_r + 16'(1);
    end
  end

  assign inst_ready       = !fifo_full;
  assign busy             = (state != ST_IDLE) || !fifo_empty;
  assign lane_instruction = inst_r;
  assign lane_enable      = mask_r;
  assign retire_count     = retire_cnt_r;

endmodule
